// File: rtl/ofdm_pingpong_buf.sv
// ofdm_pingpong_buf
//   Double-buffered multi-channel OFDM symbol buffer. A writer streams one
//   symbol (DEPTH entries of NUM_CH samples) into one bank while a reader
//   random-accesses the previously completed symbol in the other bank.
//   Bank ownership passes writer -> reader on symbol completion and
//   reader -> writer on release.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   wr_valid     write sample present
//   wr_data      sample word, channel c at [c*DATA_W +: DATA_W]
//   wr_ready     current write bank is empty
//   wr_last      accepted write completed a symbol (combinational pulse)
//   rd_avail     current read bank holds a completed symbol
//   rd_en        read request
//   rd_addr      entry within the readable bank
//   rd_release   reader is done with the current bank
//   rd_data      registered read data (0 when no valid read)
//   rd_valid     rd_data holds a valid read
//   overflow     sticky: write attempted while wr_ready was low
module ofdm_pingpong_buf #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned DEPTH  = 36,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  output logic                     wr_ready,
  output logic                     wr_last,
  output logic                     rd_avail,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_release,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     overflow
);

  localparam int unsigned WordW = NUM_CH * DATA_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  // Storage is deliberately not reset.
  logic [WordW-1:0] mem_q [2][DEPTH];

  // full_q[b] set: bank b holds a completed symbol (readable or being read).
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WordW-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;

  logic wr_fire, wr_done, rd_hit, rel;

  always_comb begin
    wr_ready = ~full_q[wr_bank_q];
    rd_avail = full_q[rd_bank_q];
    wr_fire  = wr_valid & wr_ready;
    wr_done  = wr_fire & (wr_ptr_q == LastAddr);
    wr_last  = wr_done;
    rd_hit   = rd_en & rd_avail & (rd_addr <= LastAddr);
    rel      = rd_release & rd_avail;

    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q | (wr_valid & ~wr_ready);
    rd_valid_d = rd_hit;
    // Read uses the pre-release bank; a same-cycle release applies afterwards.
    rd_data_d  = rd_hit ? mem_q[rd_bank_q][rd_addr] : '0;

    if (wr_fire) begin
      if (wr_done) begin
        wr_ptr_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // A completing write and a release never target the same bank: the
    // write bank is empty while the read bank is full.
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ofdm_pingpong_buf.sv
// Testbench for ofdm_pingpong_buf: directed stimulus, a symbol-queue
// reference model checked every cycle, plus hand-computed literal checks.
module tb_ofdm_pingpong_buf;

  localparam int DATA_W = 13;
  localparam int DEPTH  = 36;
  localparam int ADDR_W = 6;
  localparam int NUM_CH = 2;
  localparam int W      = NUM_CH * DATA_W;

  typedef logic [W-1:0] word_t;
  typedef word_t sym_t [DEPTH];

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wr_valid;
  logic [W-1:0]      wr_data;
  logic              wr_ready;
  logic              wr_last;
  logic              rd_avail;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_release;
  logic [W-1:0]      rd_data;
  logic              rd_valid;
  logic              overflow;

  always #5 clk = ~clk;

  ofdm_pingpong_buf #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .wr_last   (wr_last),
    .rd_avail  (rd_avail),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_release(rd_release),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .overflow  (overflow)
  );

  int tests = 0;
  int fails = 0;

  // Model: completed symbols in write order (at most two) plus the partial one.
  sym_t  q[$];
  sym_t  cur;
  int    cnt;
  logic  ovf;
  logic  exp_v;
  word_t exp_d;

  function automatic word_t mk(int c0, int c1);
    return {13'(c1), 13'(c0)};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic idle();
    wr_valid   = 1'b0;
    wr_data    = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    rd_release = 1'b0;
  endtask

  task automatic model_clear();
    q.delete();
    cnt   = 0;
    ovf   = 1'b0;
    exp_v = 1'b0;
    exp_d = '0;
  endtask

  task automatic check();
    chk("wr_ready", wr_ready, q.size() < 2);
    chk("rd_avail", rd_avail, q.size() > 0);
    chk("wr_last", wr_last, wr_valid && (q.size() < 2) && (cnt == DEPTH - 1));
    chk("overflow", overflow, ovf);
    chk("rd_valid", rd_valid, exp_v);
    chk("rd_data", rd_data, exp_d);
  endtask

  task automatic model_update();
    bit pre_avail;
    bit pre_ready;
    pre_avail = q.size() > 0;
    pre_ready = q.size() < 2;
    exp_v = rd_en && pre_avail && (int'(rd_addr) < DEPTH);
    exp_d = exp_v ? q[0][rd_addr] : '0;
    if (wr_valid) begin
      if (pre_ready) begin
        cur[cnt] = wr_data;
        cnt++;
        if (cnt == DEPTH) begin
          q.push_back(cur);
          cnt = 0;
        end
      end else begin
        ovf = 1'b1;
      end
    end
    if (rd_release && pre_avail) q.delete(0);
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the
  // falling edge; the model advances on the rising edge.
  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_wr_last", wr_last, 0);
    chk("rst_rd_avail", rd_avail, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_overflow", overflow, 0);
    model_clear();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    model_clear();
    #1;
    do_reset();

    // Read gating with nothing buffered.
    rd_en = 1'b1; rd_addr = '0;
    step();
    idle(); rd_release = 1'b1;
    step();
    idle(); #1;
    chk("gate_rd_valid", rd_valid, 0);
    chk("gate_rd_data", rd_data, 0);
    chk("gate_rd_avail", rd_avail, 0);
    chk("gate_wr_ready", wr_ready, 1);

    // Basic symbol A.
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = mk(i, 100 + i);
      if (i == DEPTH - 2) begin #1; chk("wr_last_35th", wr_last, 0); end
      if (i == DEPTH - 1) begin #1; chk("wr_last_36th", wr_last, 1); end
      step();
    end
    idle(); #1;
    chk("a_rd_avail", rd_avail, 1);
    rd_en = 1'b1; rd_addr = 6'd5;
    step();
    idle(); #1;
    chk("a_addr5", rd_data, {13'd105, 13'd5});
    chk("a_addr5_valid", rd_valid, 1);
    step();

    // Ping-pong: symbol B fills the second bank.
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = mk(200 + i, 300 + i);
      step();
    end
    idle(); #1;
    chk("b_wr_ready", wr_ready, 0);
    wr_valid = 1'b1; wr_data = '1;
    step();
    idle(); #1;
    chk("ovf_set", overflow, 1);
    rd_en = 1'b1; rd_addr = 6'd40;
    step();
    idle(); #1;
    chk("addr40_valid", rd_valid, 0);
    chk("addr40_data", rd_data, 0);

    // Read and release in the same cycle.
    rd_en = 1'b1; rd_addr = 6'd35; rd_release = 1'b1;
    step();
    idle(); #1;
    chk("rel_read_a35", rd_data, {13'd135, 13'd35});
    chk("rel_wr_ready", wr_ready, 1);
    chk("rel_rd_avail", rd_avail, 1);
    rd_en = 1'b1; rd_addr = '0;
    step();
    idle(); #1;
    chk("b_addr0", rd_data, {13'd300, 13'd200});

    // Symbol C completes in the same cycle B is read and released.
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      wr_valid = 1'b1; wr_data = mk(400 + i, 500 + i);
      if (i == DEPTH - 1) begin rd_en = 1'b1; rd_addr = 6'd35; rd_release = 1'b1; end
      step();
    end
    idle(); #1;
    chk("b_addr35", rd_data, {13'd335, 13'd235});
    chk("c_rd_avail", rd_avail, 1);
    rd_en = 1'b1; rd_addr = '0;
    step();
    idle(); #1;
    chk("c_addr0", rd_data, {13'd500, 13'd400});
    rd_release = 1'b1;
    step();
    idle(); #1;
    chk("c_released", rd_avail, 0);

    // Streaming: 10 symbols back to back, each read fully then released.
    do_reset();
    for (int t = 0; t < 11 * DEPTH; t++) begin
      idle();
      if (t < 10 * DEPTH) begin
        wr_valid = 1'b1;
        wr_data  = mk(t, 4000 + t);
      end
      if (t >= DEPTH) begin
        rd_en      = 1'b1;
        rd_addr    = 6'(t % DEPTH);
        rd_release = (t % DEPTH) == DEPTH - 1;
      end
      step();
    end
    idle(); #1;
    chk("stream_last", rd_data, mk(359, 4359));
    step();
    chk("stream_no_ovf", overflow, 0);
    chk("stream_drained", rd_avail, 0);

    // Reset in the middle of a symbol, with a valid read pending.
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = mk(600 + i, 700 + i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      idle();
      wr_valid = 1'b1; wr_data = mk(800 + i, 900 + i);
      if (i == 19) begin rd_en = 1'b1; rd_addr = 6'd3; end
      step();
    end
    chk("pre_rst_rd_valid", rd_valid, 1);
    chk("pre_rst_rd_data", rd_data, {13'd703, 13'd603});
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = mk(1000 + i, 1100 + i);
      step();
    end
    idle(); rd_en = 1'b1; rd_addr = '0;
    step();
    idle(); #1;
    chk("fresh_addr0", rd_data, {13'd1100, 13'd1000});
    rd_en = 1'b1; rd_addr = 6'd35;
    step();
    idle(); #1;
    chk("fresh_addr35", rd_data, {13'd1135, 13'd1035});
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ofdm_pingpong_buf.md
# ofdm_pingpong_buf

Double-buffered (ping-pong) multi-channel symbol buffer for the MIMO-OFDM datapath. It is the parametrised successor of the single-bank 36-entry sample RAM. A writer streams one OFDM symbol of NUM_CH parallel samples into one bank while a reader random-accesses the previously completed symbol in the other bank. Bank ownership is handed over with full/release handshakes, so the upstream stage (e.g. demapper) and the downstream stage (e.g. subcarrier reorder / IFFT feed) run decoupled.

## Interface
- DATA_W, 13, bits per sample per channel
- DEPTH, 36, samples per symbol (entries per bank)
- ADDR_W, 6, address width; ≥ clog2(DEPTH)
- NUM_CH, 2, parallel channels (antennas) stored side by side per entry
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write sample present this cycle
- wr_data  in  NUM_CH*DATA_W  sample word; channel c occupies bits [c*DATA_W +: DATA_W]
- wr_ready  out  1  a bank is available for writing
- wr_last  out  1  one-cycle pulse: the accepted write completed a symbol (entry DEPTH-1)
- rd_avail  out  1  a completed bank is available for reading
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  entry to read within the readable bank
- rd_release  in  1  reader has finished with the current bank
- rd_data  out  NUM_CH*DATA_W  registered read data
- rd_valid  out  1  rd_data holds a valid read
- overflow  out  1  sticky: a write was attempted while wr_ready=0

## Operation
- Storage: two banks of DEPTH × (NUM_CH*DATA_W). Memory contents are not reset.
- Per-bank state: EMPTY, then FULL, then EMPTY. FULL covers both "readable" and "being read".
- Write side:
  - Pointers wr_bank and wr_ptr (0..DEPTH-1).
  - wr_ready = (state[wr_bank]==EMPTY).
  - Write accepted when wr_valid && wr_ready. It stores wr_data at [wr_bank][wr_ptr], then increments wr_ptr.
  - The accepted write with wr_ptr==DEPTH-1 does the following: wr_ptr wraps to 0, state[wr_bank] becomes FULL, wr_bank toggles, and wr_last pulses.
  - wr_valid && !wr_ready: data is dropped, pointers are unchanged, and overflow is set until reset.
- Read side:
  - Pointer rd_bank. rd_avail = (state[rd_bank]==FULL).
  - rd_en && rd_avail && rd_addr<DEPTH: rd_data receives [rd_bank][rd_addr] and rd_valid=1 the next cycle.
  - Any other cycle (rd_en=0, no bank available, or rd_addr≥DEPTH): rd_data=0 and rd_valid=0 the next cycle.
  - rd_release && rd_avail: state[rd_bank] becomes EMPTY and rd_bank toggles. rd_release while !rd_avail is ignored.
- Simultaneous events:
  - rd_en and rd_release in the same cycle: the read uses the bank being released, and the release takes effect after that read.
  - Completing write and release on different banks in the same cycle: both take effect.
  - Completing write and release on the same bank cannot occur, because a bank is never EMPTY and FULL at once.
- Ordering: symbols are read strictly in write order, with at most two symbols buffered.

## Timing
- Reset values (async assert, sync-safe deassert):
  - Both banks EMPTY; wr_bank=0, wr_ptr=0, rd_bank=0.
  - wr_ready=1, wr_last=0, rd_avail=0, rd_data=0, rd_valid=0, overflow=0.
- Write-to-read: the cycle after the DEPTH-th accepted write, rd_avail=1.
- Read latency: 1 cycle (address at edge N, data after edge N+1).
- Release-to-write: the cycle after a release of a previously full write target, wr_ready=1.
- Throughput: one write and one read per cycle, sustained continuous streaming when the reader releases within DEPTH cycles.
- Reset mid-symbol: the partial symbol is discarded and pointers return to 0. rd_data is forced to 0 asynchronously.

## Test plan
- **Basic symbol.** After reset, write DEPTH=36 words with value i on ch0 and 100+i on ch1.
  - wr_last pulses on the 36th write; rd_avail=1 one cycle later.
  - Reading addr 5 returns {105, 5} with rd_valid=1 one cycle after rd_en.
- **Ping-pong.** Write symbol A then symbol B with no release.
  - wr_ready drops after B; a 73rd wr_valid sets overflow and does not change contents.
  - Release: A→B becomes readable and wr_ready=1 next cycle. Reading addr 0 returns B[0].
- **Read gating.**
  - rd_en with rd_avail=0 gives rd_data=0 and rd_valid=0.
  - rd_addr=40 on an available bank gives rd_data=0 and rd_valid=0.
  - rd_release with rd_avail=0 leaves all state unchanged.
- **Simultaneous events.**
  - rd_en addr 35 plus rd_release in the same cycle returns the released bank's entry 35.
  - A completing write on the other bank in that same cycle leaves rd_avail=1 the next cycle, pointing at the new bank.
- **Streaming.** Continuous wr_valid for 10 symbols, with the reader reading all 36 entries and then releasing each symbol.
  - No overflow.
  - Data matches the write order for every symbol.
- **Reset mid-operation.** Assert rst_n=0 after 20 writes of a symbol.
  - All outputs return to reset values immediately.
  - The next 36 writes form a fresh symbol starting at entry 0.
